stage_monitor: RTL and testbench
================================

Name: stage_monitor

Overview:
- Parametrised debug/performance monitor for the GAT pipeline stages (SPMM, DMVM, softmax, aggregation, …).
- Per stage: sticky valid/ready flags, a valid-rising-edge event counter and a first-valid to first-ready latency counter.
- Also holds a free-running cycle counter and a one-shot address-triggered capture unit.
- All results are read through one registered 32-bit debug word selected by an index, feeding the board-level debug outputs.

Parameters:
- NUM_STAGES, 4, number of monitored handshake pairs (1..16).
- CNT_W, 32, width of every counter (1..32); counters saturate at all-ones.
- ADDR_W, 16, width of trigger address compare.
- CAP_W, 32, width of captured data (1..32).
- SEL_W, 8, width of readout select.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear of all monitor state.
- vld_i  in  NUM_STAGES  per-stage valid level.
- rdy_i  in  NUM_STAGES  per-stage ready/done level.
- arm_i  in  1  one-cycle pulse that arms the capture unit.
- trig_en_i  in  1  qualifier for the address compare (e.g. BRAM write enable).
- trig_addr_i  in  ADDR_W  address being observed.
- match_addr_i  in  ADDR_W  trigger address (quasi-static config).
- cap_data_i  in  CAP_W  data latched on trigger.
- sel_i  in  SEL_W  readout index.
- dbg_o  out  32  registered readout word.
- captured_o  out  1  high while capture FSM is in DONE.

Behaviour:
- Async reset (rst_n=0) zeroes everything immediately: all flags, counters, the capture register, the timestamp and dbg_o. It also zeroes the vld_i delay register. FSM goes to IDLE and captured_o=0.
- clear_i=1 does the same as reset, but on the clock edge. It has priority over every event in the same cycle.
- Sticky flags: vld_seen[k] is set on any cycle with vld_i[k]=1; rdy_seen[k] is set likewise from rdy_i[k]. Both are cleared only by reset/clear.
- Event count evt[k] increments on each rising edge, i.e. vld_i[k]=1 and vld_d[k]=0.
  - vld_d is vld_i registered one cycle.
  - evt[k] saturates at 2^CNT_W-1.
- Latency lat[k] increments each cycle where vld_seen[k]=1 and rdy_seen[k]=0 (registered values), saturating.
  - vld_i first high at cycle t, rdy_i first high at t+n: lat=n.
  - vld_i and rdy_i first high in the same cycle: lat=0.
  - rdy_i before any vld_i: lat stays 0.
- Cycle counter cyc increments every cycle after reset/clear and saturates.
- Capture FSM:
  - IDLE: on arm_i go to ARMED.
  - ARMED: when trig_en_i=1 and trig_addr_i==match_addr_i, latch cap_data_i (zero-extended to 32) into cap_reg. In the same edge, latch the current cyc into cap_ts and go to DONE. If the trigger and a repeated arm_i coincide, the trigger wins.
  - DONE: holds; arm_i and triggers are ignored. Only reset/clear return it to IDLE.
  - A trigger while in IDLE is ignored.
  - State encoding: IDLE=0, ARMED=1, DONE=2.
- Readout: dbg_o is registered, so the value for sel_i appears one cycle later. The selected value is the state before that edge's update. Counters narrower than 32 bits are zero-extended.
  - sel 0: status. Bit 2k = vld_seen[k], bit 2k+1 = rdy_seen[k]; unused bits are 0.
  - sel 1: cyc.
  - sel 2: cap_reg.
  - sel 3: cap_ts.
  - sel 4: {30'b0, fsm_state}.
  - sel 8+2k: evt[k].
  - sel 9+2k: lat[k].
  - Any other index returns 32'hDEAD_BEEF.

Test Plan:
- Reset mid-run: assert rst_n=0 after 50 cycles of activity -> dbg_o=0 and captured_o=0 asynchronously; after release, sel 1 reads 0 on the first read, then increments by 1 per cycle.
- Latency: NUM_STAGES=4, vld_i[1] high at cycle 10, rdy_i[1] high at cycle 17 -> sel 11 reads 7 and sel 0 reads 32'h0000_000C. vld_i[2] and rdy_i[2] both high at cycle 20 -> sel 13 reads 0.
- Event count: vld_i[0] toggles 0/1 for 5 pulses, then held high 10 cycles -> sel 8 reads 6. With CNT_W=3, 9 pulses -> sel 8 reads 7 (saturated).
- Capture: match_addr_i=43328; arm at cycle 5; trig_addr_i=43328 with trig_en_i=0 at cycle 8 -> no capture. Same address with trig_en_i=1 and cap_data_i=32'h1234 at cycle 12 -> sel 2 reads 32'h1234, sel 3 reads 12, sel 4 reads 2, captured_o=1. A later match with new data leaves sel 2 unchanged.
- Trigger without arm: a match while in IDLE -> sel 4 reads 0, sel 2 reads 0. Then clear_i coinciding with an active rising edge on vld_i[3] -> all counters read 0 next cycle.
- Invalid select: sel_i=200 -> dbg_o=32'hDEAD_BEEF one cycle later.

Source files
------------

// File: rtl/stage_monitor.sv
// Debug/performance monitor for GAT pipeline stages: per-stage handshake flags,
// event and latency counters, a cycle counter and a one-shot address-triggered capture.
module stage_monitor #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32,
    parameter int ADDR_W     = 16,
    parameter int CAP_W      = 32,
    parameter int SEL_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic [NUM_STAGES-1:0] vld_i,
    input  logic [NUM_STAGES-1:0] rdy_i,
    input  logic                  arm_i,
    input  logic                  trig_en_i,
    input  logic [ADDR_W-1:0]     trig_addr_i,
    input  logic [ADDR_W-1:0]     match_addr_i,
    input  logic [CAP_W-1:0]      cap_data_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [31:0]           dbg_o,
    output logic                  captured_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } cap_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_STAGES-1:0] vld_seen;
    logic [NUM_STAGES-1:0] rdy_seen;
    logic [NUM_STAGES-1:0] vld_d;
    logic [CNT_W-1:0]      evt [NUM_STAGES];
    logic [CNT_W-1:0]      lat [NUM_STAGES];
    logic [CNT_W-1:0]      cyc;
    logic [CNT_W-1:0]      cap_ts;
    logic [CAP_W-1:0]      cap_reg;
    cap_state_t            state;
    cap_state_t            next_state;
    logic                  fire;
    logic [31:0]           rd_word;
    logic [31:0]           sel_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_seen <= '0;
            rdy_seen <= '0;
            vld_d    <= '0;
        end else if (clear_i) begin
            vld_seen <= '0;
            rdy_seen <= '0;
            vld_d    <= '0;
        end else begin
            vld_seen <= vld_seen | vld_i;
            rdy_seen <= rdy_seen | rdy_i;
            vld_d    <= vld_i;
        end
    end

    // Latency counts while the registered flags say "valid seen, ready not yet seen".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                evt[k] <= '0;
                lat[k] <= '0;
            end
        end else if (clear_i) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                evt[k] <= '0;
                lat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (vld_i[k] && !vld_d[k] && evt[k] != CNT_MAX)
                    evt[k] <= evt[k] + CNT_W'(1);
                if (vld_seen[k] && !rdy_seen[k] && lat[k] != CNT_MAX)
                    lat[k] <= lat[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc <= '0;
        else if (clear_i)
            cyc <= '0;
        else if (cyc != CNT_MAX)
            cyc <= cyc + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (clear_i)
            state <= IDLE;
        else
            state <= next_state;
    end

    // A trigger in ARMED takes precedence over a repeated arm in the same cycle.
    always_comb begin
        next_state = state;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (arm_i)
                    next_state = ARMED;
            end
            ARMED: begin
                if (trig_en_i && trig_addr_i == match_addr_i) begin
                    fire       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_reg <= '0;
            cap_ts  <= '0;
        end else if (clear_i) begin
            cap_reg <= '0;
            cap_ts  <= '0;
        end else if (fire) begin
            cap_reg <= cap_data_i;
            cap_ts  <= cyc;
        end
    end

    assign captured_o = (state == DONE);
    assign sel_ext    = 32'(sel_i);

    always_comb begin
        rd_word = 32'hDEAD_BEEF;
        case (sel_ext)
            32'd0: begin
                rd_word = '0;
                for (int k = 0; k < NUM_STAGES; k++) begin
                    rd_word[2*k]   = vld_seen[k];
                    rd_word[2*k+1] = rdy_seen[k];
                end
            end
            32'd1:   rd_word = 32'(cyc);
            32'd2:   rd_word = 32'(cap_reg);
            32'd3:   rd_word = 32'(cap_ts);
            32'd4:   rd_word = {30'b0, state};
            default: begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (sel_ext == 32'(8 + 2*k))
                        rd_word = 32'(evt[k]);
                    if (sel_ext == 32'(9 + 2*k))
                        rd_word = 32'(lat[k]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dbg_o <= '0;
        else if (clear_i)
            dbg_o <= '0;
        else
            dbg_o <= rd_word;
    end

endmodule

// File: tb/tb_stage_monitor.sv
// Self-checking bench for stage_monitor: directed scenarios plus random traffic,
// compared every cycle against a count-based reference model (32-bit and 3-bit counter instances).
module tb_stage_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  vld = '0;
    logic [3:0]  rdy = '0;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [15:0] trig_addr = '0;
    logic [15:0] match_addr = '0;
    logic [31:0] cap_data = '0;
    logic [7:0]  sel = '0;
    logic [31:0] dbg, dbg_sat;
    logic        captured, captured_sat;

    int checks = 0;
    int fails = 0;

    // Reference model: plain unbounded counts, saturation applied only when read.
    longint mCyc, mCap, mTs;
    longint mEvt [4];
    longint mLat [4];
    bit     mVs [4];
    bit     mRs [4];
    bit     mVd [4];
    int     mState;

    always #5 clk = ~clk;

    stage_monitor #(.NUM_STAGES(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .vld_i(vld), .rdy_i(rdy),
        .arm_i(arm), .trig_en_i(trig_en), .trig_addr_i(trig_addr),
        .match_addr_i(match_addr), .cap_data_i(cap_data), .sel_i(sel),
        .dbg_o(dbg), .captured_o(captured)
    );

    stage_monitor #(.NUM_STAGES(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .vld_i(vld), .rdy_i(rdy),
        .arm_i(arm), .trig_en_i(trig_en), .trig_addr_i(trig_addr),
        .match_addr_i(match_addr), .cap_data_i(cap_data), .sel_i(sel),
        .dbg_o(dbg_sat), .captured_o(captured_sat)
    );

    function automatic longint sat(longint x, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic void modelReset();
        mCyc = 0; mCap = 0; mTs = 0; mState = 0;
        for (int k = 0; k < 4; k++) begin
            mEvt[k] = 0; mLat[k] = 0; mVs[k] = 0; mRs[k] = 0; mVd[k] = 0;
        end
    endfunction

    function automatic logic [31:0] readModel(int s, int w);
        logic [31:0] r;
        r = 32'hDEAD_BEEF;
        if (s == 0) begin
            r = '0;
            for (int k = 0; k < 4; k++) begin
                r[2*k]   = mVs[k];
                r[2*k+1] = mRs[k];
            end
        end else if (s == 1) r = 32'(sat(mCyc, w));
        else if (s == 2)     r = 32'(mCap);
        else if (s == 3)     r = 32'(sat(mTs, w));
        else if (s == 4)     r = 32'(mState);
        else if (s >= 8 && s < 16) begin
            if (s % 2 == 0) r = 32'(sat(mEvt[(s-8)/2], w));
            else            r = 32'(sat(mLat[(s-9)/2], w));
        end
        return r;
    endfunction

    function automatic void modelStep();
        longint oldCyc;
        if (clear) begin
            modelReset();
            return;
        end
        oldCyc = mCyc;
        for (int k = 0; k < 4; k++) begin
            if (vld[k] && !mVd[k]) mEvt[k]++;
            if (mVs[k] && !mRs[k]) mLat[k]++;
        end
        for (int k = 0; k < 4; k++) begin
            mVs[k] = mVs[k] | vld[k];
            mRs[k] = mRs[k] | rdy[k];
            mVd[k] = vld[k];
        end
        if (mState == 1 && trig_en && trig_addr == match_addr) begin
            mCap   = longint'(cap_data);
            mTs    = oldCyc;
            mState = 2;
        end else if (mState == 0 && arm) begin
            mState = 1;
        end
        mCyc++;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict, clock, then compare both instances against the model.
    task automatic applyStimulus();
        logic [31:0] expDbg, expSat;
        expDbg = clear ? 32'd0 : readModel(int'(sel), 32);
        expSat = clear ? 32'd0 : readModel(int'(sel), 3);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("dbg", dbg, expDbg);
        checkOutput("dbg_sat", dbg_sat, expSat);
        checkOutput("captured", 32'(captured), 32'(mState == 2));
        checkOutput("captured_sat", 32'(captured_sat), 32'(mState == 2));
    endtask

    task automatic idleInputs();
        clear = 0; vld = '0; rdy = '0; arm = 0; trig_en = 0;
        trig_addr = '0; cap_data = '0; sel = 8'd0;
    endtask

    task automatic clearCycle();
        idleInputs();
        clear = 1;
        applyStimulus();
        clear = 0;
    endtask

    initial begin
        modelReset();
        #12;
        checkOutput("reset_dbg", dbg, 32'd0);
        checkOutput("reset_captured", 32'(captured), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1;
        #3;

        // Latency: stage 1 valid at 10, ready at 17; stage 2 both at 20.
        clearCycle();
        for (int i = 0; i < 25; i++) begin
            vld[1] = (i >= 10);
            rdy[1] = (i >= 17);
            vld[2] = (i >= 20);
            rdy[2] = (i >= 20);
            sel = (i == 19) ? 8'd0 : 8'd1;
            applyStimulus();
            if (i == 19) checkOutput("status_stage1", dbg, 32'h0000_000C);
        end
        sel = 8'd11; applyStimulus(); checkOutput("lat1", dbg, 32'd7);
        sel = 8'd13; applyStimulus(); checkOutput("lat2_same_cycle", dbg, 32'd0);

        // Event count: five pulses then held high -> 6 rising edges.
        clearCycle();
        for (int p = 0; p < 5; p++) begin
            vld[0] = 1; applyStimulus();
            vld[0] = 0; applyStimulus();
        end
        vld[0] = 1;
        for (int i = 0; i < 10; i++) applyStimulus();
        sel = 8'd8; applyStimulus();
        checkOutput("evt0_six", dbg, 32'd6);
        checkOutput("evt0_six_sat", dbg_sat, 32'd6);

        // Nine pulses saturate the 3-bit instance at 7.
        clearCycle();
        for (int p = 0; p < 9; p++) begin
            vld[0] = 1; applyStimulus();
            vld[0] = 0; applyStimulus();
        end
        sel = 8'd8; applyStimulus();
        checkOutput("evt0_nine", dbg, 32'd9);
        checkOutput("evt0_saturated", dbg_sat, 32'd7);

        // Capture: arm at 5, unqualified match at 8, qualified match at 12, late match at 14.
        match_addr = 16'd43328;
        clearCycle();
        for (int i = 0; i < 16; i++) begin
            arm       = (i == 5);
            trig_addr = (i == 8 || i == 12 || i == 14) ? 16'd43328 : 16'd0;
            trig_en   = (i == 12 || i == 14);
            cap_data  = (i == 14) ? 32'h0000_5555 : 32'h0000_1234;
            sel       = 8'd4;
            applyStimulus();
            if (i == 8) checkOutput("no_capture_without_en", 32'(captured), 32'd0);
        end
        idleInputs();
        sel = 8'd2; applyStimulus(); checkOutput("cap_reg", dbg, 32'h0000_1234);
        sel = 8'd3; applyStimulus(); checkOutput("cap_ts", dbg, 32'd12);
        sel = 8'd4; applyStimulus(); checkOutput("fsm_done", dbg, 32'd2);
        checkOutput("captured_high", 32'(captured), 32'd1);

        // Trigger while idle is ignored; then clear coinciding with a vld rising edge.
        clearCycle();
        trig_en = 1; trig_addr = 16'd43328; cap_data = 32'h0000_ABCD;
        for (int i = 0; i < 3; i++) applyStimulus();
        sel = 8'd4; applyStimulus(); checkOutput("idle_trig_state", dbg, 32'd0);
        sel = 8'd2; applyStimulus(); checkOutput("idle_trig_cap", dbg, 32'd0);
        idleInputs();
        applyStimulus();
        clear = 1; vld[3] = 1; applyStimulus();
        clear = 0; vld[3] = 0;
        sel = 8'd1;  applyStimulus(); checkOutput("clear_cyc", dbg, 32'd0);
        sel = 8'd14; applyStimulus(); checkOutput("clear_evt3", dbg, 32'd0);

        // Invalid selects.
        sel = 8'd200; applyStimulus(); checkOutput("sel_200", dbg, 32'hDEAD_BEEF);
        sel = 8'd5;   applyStimulus(); checkOutput("sel_5", dbg, 32'hDEAD_BEEF);

        // Random traffic with occasional clears.
        match_addr = 16'd2;
        for (int i = 0; i < 400; i++) begin
            clear     = ($urandom_range(0, 49) == 0);
            vld       = 4'($urandom);
            rdy       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            arm       = ($urandom_range(0, 15) == 0);
            trig_en   = 1'($urandom);
            trig_addr = 16'($urandom_range(0, 3));
            cap_data  = $urandom;
            sel       = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 16));
            applyStimulus();
        end

        // Mid-run reset after 50 cycles of activity.
        for (int i = 0; i < 50; i++) begin
            vld = 4'($urandom); rdy = 4'($urandom); sel = 8'd1;
            arm = (i == 3); trig_en = 1; trig_addr = 16'd2; cap_data = $urandom;
            applyStimulus();
        end
        #2;
        rst_n = 0;
        #1;
        modelReset();
        checkOutput("async_reset_dbg", dbg, 32'd0);
        checkOutput("async_reset_captured", 32'(captured), 32'd0);
        idleInputs();
        @(posedge clk);
        #3;
        rst_n = 1;
        #3;
        sel = 8'd1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("cyc_after_reset", dbg, 32'(i));
        end

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
